seg7_scan_counter: RTL

//  Multi-digit up/down counter that drives a multiplexed common-bus 7-segment display.

---
 rtl/seg7_pkg.sv | 26 ++
 rtl/seg7_decode.sv | 34 +++
 rtl/seg7_scan_counter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan counter: segment patterns (bit0=a .. bit6=g)
// and the per-digit radices.
package seg7_pkg;

    localparam int RADIX_DEC = 10;
    localparam int RADIX_HEX = 16;

    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;
    localparam logic [6:0] SEG_A = 7'h77;
    localparam logic [6:0] SEG_B = 7'h7C;
    localparam logic [6:0] SEG_C = 7'h39;
    localparam logic [6:0] SEG_D = 7'h5E;
    localparam logic [6:0] SEG_E = 7'h79;
    localparam logic [6:0] SEG_F = 7'h71;

endpackage

// File: rtl/seg7_decode.sv
// Combinational 4-bit value to 7-segment pattern decoder with a blanking override.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] value,
    input  logic       blank,
    output logic [6:0] pattern
);

    always_comb begin
        pattern = SEG_BLANK;
        if (!blank) begin
            case (value)
                4'h0:    pattern = SEG_0;
                4'h1:    pattern = SEG_1;
                4'h2:    pattern = SEG_2;
                4'h3:    pattern = SEG_3;
                4'h4:    pattern = SEG_4;
                4'h5:    pattern = SEG_5;
                4'h6:    pattern = SEG_6;
                4'h7:    pattern = SEG_7;
                4'h8:    pattern = SEG_8;
                4'h9:    pattern = SEG_9;
                4'hA:    pattern = SEG_A;
                4'hB:    pattern = SEG_B;
                4'hC:    pattern = SEG_C;
                4'hD:    pattern = SEG_D;
                4'hE:    pattern = SEG_E;
                default: pattern = SEG_F;
            endcase
        end
    end

endmodule

// File: rtl/seg7_scan_counter.sv
// Multi-digit decimal/hex up/down counter with prescaled tick, multiplexed digit scan
// and optional leading-zero blanking.
module seg7_scan_counter
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int TICK_DIV   = 10_000_000,
    parameter int SCAN_DIV   = 10_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic                  count_en,
    input  logic                  up_dn,
    input  logic                  mode_hex,
    input  logic                  blank_lz,
    input  logic                  clear,
    output logic [6:0]            segments,
    output logic [NUM_DIGITS-1:0] digit_sel,
    output logic                  rollover
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [PW-1:0]         TICK_LAST = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0]         SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0]         IDX_LAST  = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] SEL_ONE   = NUM_DIGITS'(1);

    logic [PW-1:0]         presc;
    logic [SW-1:0]         scan_cnt;
    logic [IW-1:0]         scan_idx;
    logic                  mode_q;
    logic [3:0]            digits [NUM_DIGITS];
    logic [NUM_DIGITS:0]   carry;
    logic [NUM_DIGITS-1:0] zero_from;
    logic                  tick;
    logic                  step;
    logic                  wipe;
    logic [3:0]            digit_max;
    logic                  blank_sel;
    logic [6:0]            dec_pattern;

    assign tick      = (presc == TICK_LAST);
    assign step      = tick & count_en;
    // A radix change invalidates the stored digits, so it wipes them like clear does.
    assign wipe      = clear | (mode_hex != mode_q);
    assign digit_max = mode_hex ? 4'(RADIX_HEX - 1) : 4'(RADIX_DEC - 1);
    assign carry[0]  = 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc  <= '0;
            mode_q <= 1'b0;
        end else if (ena) begin
            presc  <= (clear || tick) ? '0 : presc + PW'(1);
            mode_q <= mode_hex;
        end
    end

    // Each digit advances only when every lower digit sits at its wrap value.
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        logic at_edge;
        assign at_edge    = up_dn ? (digits[i] == digit_max) : (digits[i] == 4'd0);
        assign carry[i+1] = carry[i] & at_edge;

        if (i == NUM_DIGITS - 1) begin : g_top
            assign zero_from[i] = (digits[i] == 4'd0);
        end else begin : g_low
            assign zero_from[i] = (digits[i] == 4'd0) & zero_from[i+1];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                digits[i] <= '0;
            end else if (ena) begin
                if (wipe) begin
                    digits[i] <= '0;
                end else if (step && carry[i]) begin
                    if (at_edge) begin
                        digits[i] <= up_dn ? 4'd0 : digit_max;
                    end else begin
                        digits[i] <= up_dn ? digits[i] + 4'd1 : digits[i] - 4'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            scan_idx <= '0;
        end else if (ena) begin
            if (scan_cnt == SCAN_LAST) begin
                scan_cnt <= '0;
                scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + IW'(1);
            end else begin
                scan_cnt <= scan_cnt + SW'(1);
            end
        end
    end

    assign blank_sel = blank_lz & (scan_idx != '0) & zero_from[scan_idx];

    seg7_decode u_decode (
        .value   (digits[scan_idx]),
        .blank   (blank_sel),
        .pattern (dec_pattern)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            segments  <= '0;
            digit_sel <= '0;
            rollover  <= 1'b0;
        end else if (ena) begin
            segments  <= dec_pattern;
            digit_sel <= SEL_ONE << scan_idx;
            rollover  <= step & carry[NUM_DIGITS] & ~wipe;
        end else begin
            rollover  <= 1'b0;
        end
    end

endmodule
